// File: rtl/lr_call_ctrl_if.sv
// Requester-side handshake bundle for lr_call_ctrl: call/return level requests,
// completion pulses, and the return-address valid/ack channel.
interface lr_call_ctrl_if #(
    parameter int SIZE = 32
);
    logic            call_req;
    logic            ret_req;
    logic [SIZE-1:0] pc;
    logic            call_done;
    logic            ret_done;
    logic            ret_valid;
    logic [SIZE-1:0] ret_addr;
    logic            ret_ack;
    logic            ready;

    modport master (
        output call_req,
        output ret_req,
        output pc,
        output ret_ack,
        input  call_done,
        input  ret_done,
        input  ret_valid,
        input  ret_addr,
        input  ready
    );

    modport slave (
        input  call_req,
        input  ret_req,
        input  pc,
        input  ret_ack,
        output call_done,
        output ret_done,
        output ret_valid,
        output ret_addr,
        output ready
    );
endinterface

// File: rtl/lr_call_ctrl.sv
// Call/return sequencer for the link register backed by a circular hardware return stack.
// Optional macro LR_OVERFLOW_TRAP_EN: refuse calls on a full stack and pulse call_trap instead.
module lr_call_ctrl #(
    parameter int              SIZE        = 32,
    parameter int              DEPTH       = 4,
    parameter logic [SIZE-1:0] INITIAL_VAL = {SIZE{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    lr_call_ctrl_if.slave          ctl,
    input  logic [SIZE-1:0]        lr_value,
    output logic                   lr_ld,
    output logic [SIZE-1:0]        lr_data,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   overflow,
    output logic                   underflow
`ifdef LR_OVERFLOW_TRAP_EN
    ,
    output logic                   call_trap
`endif
);
    localparam int              PW         = $clog2(DEPTH);
    localparam int              DW         = PW + 1;
    localparam logic [PW-1:0]   PTR_ONE    = PW'(32'd1);
    localparam logic [DW-1:0]   DEPTH_ONE  = DW'(32'd1);
    localparam logic [DW-1:0]   DEPTH_FULL = DW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH    = 3'd1,
        LOAD    = 3'd2,
        RET_OUT = 3'd3,
        POP     = 3'd4
    } state_t;

    state_t          state_r;
    logic [SIZE-1:0] stack_r [DEPTH];
    logic [PW-1:0]   wp_r;
    logic [DW-1:0]   depth_r;
    logic [SIZE-1:0] pc_r;
    logic            lr_ld_r;
    logic [SIZE-1:0] lr_data_r;
    logic            ret_valid_r;
    logic [SIZE-1:0] ret_addr_r;
    logic            call_done_r;
    logic            ret_done_r;
    logic            ready_r;
    logic            overflow_r;
    logic            underflow_r;
    logic [SIZE-1:0] top_s;
    logic            trap_full_s;
`ifdef LR_OVERFLOW_TRAP_EN
    logic            trap_r;
`endif

    // Most recently pushed entry; only consulted when depth_r is non-zero.
    assign top_s = stack_r[wp_r - PTR_ONE];

`ifdef LR_OVERFLOW_TRAP_EN
    assign trap_full_s = (depth_r == DEPTH_FULL);
`else
    assign trap_full_s = 1'b0;
`endif

    // Return-stack storage: written only while pushing, no reset needed.
    always_ff @(posedge clk) begin
        if (state_r == PUSH) begin
            stack_r[wp_r] <= lr_value;
        end
    end

    // Sequencer FSM; each output register is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            wp_r        <= {PW{1'b0}};
            depth_r     <= {DW{1'b0}};
            pc_r        <= {SIZE{1'b0}};
            lr_ld_r     <= 1'b0;
            lr_data_r   <= {SIZE{1'b0}};
            ret_valid_r <= 1'b0;
            ret_addr_r  <= {SIZE{1'b0}};
            call_done_r <= 1'b0;
            ret_done_r  <= 1'b0;
            ready_r     <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
`ifdef LR_OVERFLOW_TRAP_EN
            trap_r      <= 1'b0;
`endif
        end else begin
            lr_ld_r     <= 1'b0;
            lr_data_r   <= {SIZE{1'b0}};
            call_done_r <= 1'b0;
            ret_done_r  <= 1'b0;
`ifdef LR_OVERFLOW_TRAP_EN
            trap_r      <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (ctl.call_req && trap_full_s) begin
                        // Refused call: stay idle, the requester must drop call_req.
                        overflow_r <= 1'b1;
`ifdef LR_OVERFLOW_TRAP_EN
                        trap_r     <= 1'b1;
`endif
                    end else if (ctl.call_req) begin
                        pc_r    <= ctl.pc;
                        ready_r <= 1'b0;
                        state_r <= PUSH;
                    end else if (ctl.ret_req) begin
                        ret_valid_r <= 1'b1;
                        ret_addr_r  <= lr_value;
                        ready_r     <= 1'b0;
                        state_r     <= RET_OUT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PUSH: begin
                    wp_r <= wp_r + PTR_ONE;
                    if (depth_r == DEPTH_FULL) begin
                        overflow_r <= 1'b1;
                    end else begin
                        depth_r <= depth_r + DEPTH_ONE;
                    end
                    lr_ld_r     <= 1'b1;
                    lr_data_r   <= pc_r;
                    call_done_r <= 1'b1;
                    state_r     <= LOAD;
                end
                LOAD: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                RET_OUT: begin
                    if (ctl.ret_ack) begin
                        ret_valid_r <= 1'b0;
                        ret_addr_r  <= {SIZE{1'b0}};
                        lr_ld_r     <= 1'b1;
                        ret_done_r  <= 1'b1;
                        lr_data_r   <= (depth_r != {DW{1'b0}}) ? top_s : INITIAL_VAL;
                        state_r     <= POP;
                    end else begin
                        state_r <= RET_OUT;
                    end
                end
                POP: begin
                    if (depth_r != {DW{1'b0}}) begin
                        wp_r    <= wp_r - PTR_ONE;
                        depth_r <= depth_r - DEPTH_ONE;
                    end else begin
                        underflow_r <= 1'b1;
                    end
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    ret_valid_r <= 1'b0;
                    ret_addr_r  <= {SIZE{1'b0}};
                    ready_r     <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign lr_ld         = lr_ld_r;
    assign lr_data       = lr_data_r;
    assign depth         = depth_r;
    assign overflow      = overflow_r;
    assign underflow     = underflow_r;
    assign ctl.call_done = call_done_r;
    assign ctl.ret_done  = ret_done_r;
    assign ctl.ret_valid = ret_valid_r;
    assign ctl.ret_addr  = ret_addr_r;
    assign ctl.ready     = ready_r;
`ifdef LR_OVERFLOW_TRAP_EN
    assign call_trap     = trap_r;
`endif

endmodule

// File: tb/tb_lr_call_ctrl.sv
// Scoreboard bench for lr_call_ctrl: stimulus pushes expectations from a queue-based
// return-stack model, a negedge monitor pops and compares whenever the DUT responds.
module tb_lr_call_ctrl;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] INIT_V = 32'hDEAD_0000;

    typedef struct packed { logic is_call; logic [31:0] data; } ld_t;
    typedef struct packed { logic [2:0] depth; logic ovf; logic unf; } st_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] lr_drv;
    logic        lr_ld;
    logic [31:0] lr_data;
    logic [2:0]  depth;
    logic        overflow;
    logic        underflow;
    wire         trap_w;

    lr_call_ctrl_if #(.SIZE(32)) ctl_if ();

    lr_call_ctrl #(.SIZE(32), .DEPTH(DEPTH), .INITIAL_VAL(INIT_V)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .ctl       (ctl_if),
        .lr_value  (lr_drv),
        .lr_ld     (lr_ld),
        .lr_data   (lr_data),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef LR_OVERFLOW_TRAP_EN
        ,
        .call_trap (trap_w)
`endif
    );
`ifndef LR_OVERFLOW_TRAP_EN
    assign trap_w = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expectation queues and the reference return stack (oldest at front).
    ld_t         exp_ld[$];
    logic [31:0] exp_ret[$];
    st_t         exp_st[$];
    logic [31:0] mstk[$];
    logic        m_ovf;
    logic        m_unf;

    int          n_vec = 0;
    int          n_fail = 0;
    ld_t         mon_ld;
    st_t         mon_st;
    logic [31:0] cur_ret;
    bit          ret_active;

    // Monitor: compares every DUT response against the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            ret_active = 1'b0;
        end else begin
            if (ctl_if.ret_valid) begin
                if (!ret_active) begin
                    ret_active = 1'b1;
                    if (exp_ret.size() == 0) begin
                        cur_ret = 32'h0;
                        n_vec++; n_fail++;
                        $display("FAIL unexpected_ret_valid: ret_addr=%h, required no return pending", ctl_if.ret_addr);
                    end else begin
                        cur_ret = exp_ret.pop_front();
                    end
                end
                n_vec++;
                if (ctl_if.ret_addr !== cur_ret || ctl_if.ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ret_addr: got %h ready=%b, required %h ready=0", ctl_if.ret_addr, ctl_if.ready, cur_ret);
                end
            end else begin
                ret_active = 1'b0;
            end
            if (lr_ld) begin
                n_vec++;
                if (exp_ld.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_lr_ld: lr_data=%h, required no load", lr_data);
                end else begin
                    mon_ld = exp_ld.pop_front();
                    if (lr_data !== mon_ld.data || ctl_if.call_done !== mon_ld.is_call ||
                        ctl_if.ret_done !== !mon_ld.is_call || ctl_if.ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL lr_load: lr_data=%h call_done=%b ret_done=%b ready=%b, required lr_data=%h call_done=%b ret_done=%b ready=0",
                                 lr_data, ctl_if.call_done, ctl_if.ret_done, ctl_if.ready,
                                 mon_ld.data, mon_ld.is_call, !mon_ld.is_call);
                    end
                end
            end else if (ctl_if.call_done || ctl_if.ret_done) begin
                n_vec++; n_fail++;
                $display("FAIL stray_done: call_done=%b ret_done=%b without lr_ld, required 0 0", ctl_if.call_done, ctl_if.ret_done);
            end
            if (exp_st.size() > 0) begin
                mon_st = exp_st.pop_front();
                n_vec++;
                if (depth !== mon_st.depth || overflow !== mon_st.ovf || underflow !== mon_st.unf ||
                    ctl_if.ready !== 1'b1 || ctl_if.ret_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_status: depth=%0d ovf=%b unf=%b ready=%b ret_valid=%b, required depth=%0d ovf=%b unf=%b ready=1 ret_valid=0",
                             depth, overflow, underflow, ctl_if.ready, ctl_if.ret_valid, mon_st.depth, mon_st.ovf, mon_st.unf);
                end
                n_vec++;
                if (exp_ld.size() != 0 || exp_ret.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending: %0d loads and %0d returns never seen, required 0 0", exp_ld.size(), exp_ret.size());
                end
            end
        end
    end

    task automatic push_status();
        st_t s;
        s.depth = 3'(mstk.size());
        s.ovf   = m_ovf;
        s.unf   = m_unf;
        exp_st.push_back(s);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_for(input int which, input string name);
        int   n;
        logic hit;
        n = 0;
        forever begin
            case (which)
                0:       hit = ctl_if.call_done;
                1:       hit = ctl_if.ret_valid;
                2:       hit = ctl_if.ret_done;
                default: hit = trap_w;
            endcase
            if (hit) break;
            if (n >= 40) begin
                $display("FAIL timeout_%s: no response after %0d cycles, required one within 40", name, n);
                $fatal(1, "bench stopped on timeout");
            end
            @(negedge clk);
            n++;
        end
    endtask

    // One call and/or return request (both raised together when c and r are set).
    task automatic op(input bit c, input bit r, input logic [31:0] pcv, input int d);
        bit          trap;
        ld_t         e;
        logic [31:0] v;
        trap = 1'b0;
`ifdef LR_OVERFLOW_TRAP_EN
        trap = c && (mstk.size() == DEPTH);
`endif
        if (c) begin
            if (trap) begin
                m_ovf = 1'b1;
            end else begin
                if (mstk.size() == DEPTH) begin
                    void'(mstk.pop_front());
                    m_ovf = 1'b1;
                end
                mstk.push_back(lr_drv);
                e.is_call = 1'b1; e.data = pcv;
                exp_ld.push_back(e);
            end
        end
        v = lr_drv;
        if (r) begin
            exp_ret.push_back((c && !trap) ? pcv : lr_drv);
            if (mstk.size() > 0) begin
                v = mstk.pop_back();
            end else begin
                v = INIT_V;
                m_unf = 1'b1;
            end
            e.is_call = 1'b0; e.data = v;
            exp_ld.push_back(e);
        end
        ctl_if.pc       = pcv;
        ctl_if.call_req = c;
        ctl_if.ret_req  = r;
        ctl_if.ret_ack  = (d == 0);
        if (c) begin
            wait_for(trap ? 3 : 0, trap ? "call_trap" : "call_done");
            ctl_if.call_req = 1'b0;
            ctl_if.pc       = $urandom;
            if (!trap) lr_drv = pcv;
        end
        if (r) begin
            wait_for(1, "ret_valid");
            repeat (d) @(negedge clk);
            ctl_if.ret_ack = 1'b1;
            wait_for(2, "ret_done");
            ctl_if.ret_req = 1'b0;
            ctl_if.ret_ack = 1'b0;
            lr_drv = v;
        end
        @(negedge clk);
        push_status();
    endtask

    task automatic do_reset(input bit mid_push);
        if (mid_push) begin
            ctl_if.call_req = 1'b1;
            ctl_if.pc       = $urandom;
            @(negedge clk);
        end
        rst_n = 1'b0;
        ctl_if.call_req = 1'b0;
        ctl_if.ret_req  = 1'b0;
        ctl_if.ret_ack  = 1'b0;
        mstk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_status();
    endtask

    initial begin
        bit c;
        bit r;
        rst_n           = 1'b0;
        lr_drv          = 32'h0;
        ctl_if.call_req = 1'b0;
        ctl_if.ret_req  = 1'b0;
        ctl_if.ret_ack  = 1'b0;
        ctl_if.pc       = 32'h0;
        m_ovf           = 1'b0;
        m_unf           = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_status();

        do_reset(1'b1);

        lr_drv = 32'h100;
        op(1'b1, 1'b0, 32'h2000, 0);
        op(1'b0, 1'b1, 32'h0, 3);

        for (int k = 1; k <= 5; k++) begin
            lr_drv = 32'(k);
            op(1'b1, 1'b0, $urandom, 0);
        end
        for (int k = 0; k < 5; k++) begin
            op(1'b0, 1'b1, 32'h0, int'($urandom_range(0, 3)));
        end

        op(1'b1, 1'b1, 32'h3000, 1);

        do_reset(1'b0);
        for (int k = 0; k < 40; k++) begin
            c = 1'($urandom_range(0, 1));
            r = c ? 1'($urandom_range(0, 1)) : 1'b1;
            if (($urandom_range(0, 3)) == 0) lr_drv = $urandom;
            op(c, r, $urandom, int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/lr_call_ctrl.md
Name: lr_call_ctrl

Overview:
- Call/return sequencer for the link register.
- Saves the current LR into a small hardware return stack on each call, then loads LR with the call PC.
- On return, presents LR as the return address through a valid/ack handshake, then reloads LR from the top of the stack.
- Sits between the control unit and the link register's synchronous load port (ld/in).

Parameters:
- SIZE, 32, data/address width.
- DEPTH, 4, return-stack entries (power of 2, >=2).
- INITIAL_VAL, 0, value loaded into LR on pop from an empty stack.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- call_req  input  1  level request; held by the requester until call_done.
- ret_req  input  1  level request; held by the requester until ret_done.
- pc  input  SIZE  call target PC; sampled when a call is accepted.
- lr_value  input  SIZE  current LR contents, from the link register's value output.
- lr_ld  output  1  drives the link register's ld.
- lr_data  output  SIZE  drives the link register's in.
- ret_valid  output  1  return address valid.
- ret_addr  output  SIZE  return address.
- ret_ack  input  1  consumer accepts ret_addr.
- call_done  output  1  one-cycle pulse: call finished.
- ret_done  output  1  one-cycle pulse: return finished.
- ready  output  1  high only in IDLE.
- depth  output  $clog2(DEPTH)+1  number of valid stack entries.
- overflow  output  1  sticky error flag.
- underflow  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, wr pointer=0, depth=0, pc latch=0, overflow=0, underflow=0. All outputs 0 except ready=1. Stack contents are don't-care.
- Reset mid-operation aborts the sequence. No lr_ld is issued after rst deasserts unless a new request arrives.
- Requests are sampled only in IDLE. If call_req and ret_req are both high, call wins. ret_req is serviced after call_done only if it is still held.
- FSM states: IDLE, PUSH, LOAD, RET_OUT, POP.
- IDLE, call_req=1 -> PUSH. The pc latch captures pc.
- PUSH (1 cycle):
  - stack[wp] <= lr_value; wp <= wp+1 mod DEPTH.
  - depth <= min(depth+1, DEPTH).
  - If depth was already DEPTH: the oldest entry is overwritten (circular) and overflow <= 1.
  - Next state: LOAD.
- LOAD (1 cycle): lr_ld=1, lr_data=pc latch, call_done=1. Next state: IDLE.
- Call latency: accept edge + 2 cycles. LR holds the new PC on the edge ending LOAD.
- IDLE, ret_req=1 (no call_req) -> RET_OUT.
- RET_OUT:
  - ret_valid=1, ret_addr=lr_value; ret_addr stays stable while waiting.
  - Stays in RET_OUT until ret_ack=1, then -> POP.
  - ret_ack outside RET_OUT is ignored.
- POP (1 cycle):
  - lr_ld=1, ret_done=1.
  - If depth>0: lr_data=stack[wp-1 mod DEPTH]; wp <= wp-1; depth <= depth-1.
  - If depth=0: lr_data=INITIAL_VAL and underflow <= 1. Pointer and depth are unchanged.
  - Next state: IDLE.
- Minimum return latency: accept edge + 2 cycles when ret_ack is already high in RET_OUT.
- lr_ld is asserted only in LOAD or POP, exactly one cycle per operation.
- overflow and underflow clear only on reset.

Optional Feature:
- Macro: LR_OVERFLOW_TRAP_EN.
- When defined: a call_req seen in IDLE with depth=DEPTH is not accepted.
  - The FSM stays in IDLE; no push and no lr_ld occur.
  - overflow <= 1.
  - A one-cycle output pulse call_trap (extra 1-bit port, present only with the macro) is asserted.
  - The request must be dropped by the requester.
- When undefined: the wrap/overwrite behaviour above applies; no call_trap port exists.

Test Plan:
- Reset: rst=0 mid-PUSH, then release -> state IDLE, ready=1, depth=0, no lr_ld pulse, flags 0.
- Single call: lr_value=0x100, pc=0x2000, call_req -> stack[0]=0x100; lr_ld=1 with lr_data=0x2000 two cycles after accept; call_done pulses; depth=1.
- Call then return: after the call above, with lr_value=0x2000, ret_req, ret_ack delayed 3 cycles -> ret_valid stays high 3 cycles with ret_addr=0x2000 stable; POP gives lr_data=0x100; depth=0; ret_done pulses.
- Overflow wrap (macro off): 5 calls with DEPTH=4 and lr_values 1..5 -> overflow=1, depth=4. 4 returns restore 5,4,3,2.
  - A 5th return gives INITIAL_VAL and underflow=1.
- Simultaneous call_req and ret_req in IDLE -> call sequence first; ret starts after call_done while ret_req is held.
- Macro on: depth=4, call_req -> call_trap pulse, no lr_ld, depth stays 4, overflow=1.
